wrapper_pass_sequencer: RTL
===========================

// Module: wrapper_pass_sequencer
// PURPOSE
//  Sequences a compute engine through NUM_PASSES start/done passes on one loaded operand set.
//  Per pass: kick engine, wait for completion, write result with a req/ack handshake, shift the
//  output register. Adds write backpressure, an engine-timeout watchdog, abort and a pass index.
//  Sits between the user/start interface and the engine + output shift/write datapath.
// PARAMETERS
//  NUM_PASSES   4     engine passes per job (>=1)
//  TIMEOUT_CYC  1024  max cycles in WAIT_ENG before timeout; 0 = watchdog disabled
//  PASS_W       $clog2(NUM_PASSES), min 1 (localparam)   width of pass_idx
//  TO_W         $clog2(TIMEOUT_CYC+1), min 1 (localparam) watchdog counter width
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       reset, asynchronous, active-high
//  start        in   1       level; held = load, falling edge = launch job
//  abort        in   1       synchronous job abort
//  eng_done     in   1       engine completion (sampled only in WAIT_ENG)
//  wr_ack       in   1       write accepted (sampled only in WRITE)
//  ld           out  1       operand register load
//  ui_ld        out  1       user-input register load
//  eng_start    out  1       one-cycle engine start pulse
//  wr_req       out  1       write request, held until wr_ack
//  sh_en        out  1       output shift enable, one cycle
//  busy         out  1       high in every state except IDLE
//  done         out  1       high in IDLE (level)
//  timeout_err  out  1       sticky watchdog flag
//  pass_idx     out  PASS_W  current pass number, 0..NUM_PASSES-1
// BEHAVIOUR
//  - Reset: state=IDLE, pass_idx=0, watchdog=0, timeout_err=0; outputs: done=1, all others 0.
//  - States: IDLE, LOAD, KICK, WAIT_ENG, WRITE. Moore outputs except sh_en (see WRITE).
//  - IDLE: start=1 -> LOAD; pass_idx<=0. done=1.
//  - LOAD: ld=ui_ld=1 every cycle; start=1 stay; start=0 -> KICK; timeout_err cleared on entry.
//  - KICK: eng_start=1 for exactly one cycle; watchdog<=0; -> WAIT_ENG.
//  - WAIT_ENG: eng_done=1 -> WRITE. Else if TIMEOUT_CYC!=0 and watchdog==TIMEOUT_CYC-1
//    -> IDLE, timeout_err<=1. Else watchdog++. eng_done and timeout same cycle: eng_done wins.
//  - WRITE: wr_req=1 until wr_ack. On wr_ack cycle: sh_en=1 (combinational, same cycle);
//    if pass_idx==NUM_PASSES-1 -> IDLE, else pass_idx++ and -> KICK.
//  - Latency per pass with immediate done/ack: KICK 1 + WAIT_ENG 1 + WRITE 1 = 3 cycles.
//  - abort=1 in any non-IDLE state: next state IDLE, no sh_en, no eng_start, pass_idx<=0,
//    timeout_err unchanged. abort beats eng_done, wr_ack, timeout in the same cycle.
//  - start ignored outside IDLE/LOAD; eng_done outside WAIT_ENG and wr_ack outside WRITE ignored.
//  - NUM_PASSES=1: single KICK/WAIT/WRITE, pass_idx stays 0.
//  - timeout_err stays 1 through IDLE until the next LOAD entry or rst.
//  - rst mid-job: immediate return to reset values; no pulses generated.
//  - Illegal state encodings recover to IDLE.
// STRUCTURE
//  - wrapper_pkg: state encoding localparams (S_IDLE..S_WRITE), PASS_W/TO_W width helper function.
//  - Sub-module wrapper_watchdog (clear, enable, TIMEOUT_CYC param, expire out); omitted logic
//    when TIMEOUT_CYC=0 via generate.
//  - Top: state register, next-state logic, pass counter, output decode.
// TESTING
//  1 Reset: assert rst mid-WAIT_ENG -> done=1, busy=0, pass_idx=0, no eng_start after release.
//  2 Nominal NUM_PASSES=4: start 3 cyc then low, eng_done and wr_ack 1 cyc after request ->
//    ld high 3 cyc, 4 eng_start pulses, 4 sh_en pulses, pass_idx 0..3, done back 12 cyc after start falls.
//  3 Backpressure: wr_ack delayed 5 cyc on pass 1 -> wr_req held 6 cyc, single sh_en, pass_idx=1 throughout.
//  4 Timeout TIMEOUT_CYC=8: eng_done never -> IDLE after 8 WAIT_ENG cycles, timeout_err=1,
//    no wr_req; next start clears flag. eng_done on cycle 8 -> WRITE, no error.
//  5 Abort: abort coincident with wr_ack on pass 2 -> no sh_en, IDLE next cycle, pass_idx=0.
//  6 NUM_PASSES=1, TIMEOUT_CYC=0: one pass completes; eng_done withheld 2000 cyc -> no timeout.

Source files
------------

// File: rtl/wrapper_pass_sequencer_pkg.sv
// Shared state encoding and width helpers for the pass sequencer.
package wrapper_pass_sequencer_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_LOAD  = 3'd1;
    localparam state_t S_KICK  = 3'd2;
    localparam state_t S_WAIT  = 3'd3;
    localparam state_t S_WRITE = 3'd4;

    // $clog2 with a floor of one bit so degenerate counts still get a port
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wrapper_pass_sequencer_if.sv
// User/engine/write-side control bundle of the pass sequencer.
interface wrapper_pass_sequencer_if #(
    parameter int PASS_W = 1
);
    logic              start;
    logic              abort;
    logic              eng_done;
    logic              wr_ack;
    logic              ld;
    logic              ui_ld;
    logic              eng_start;
    logic              wr_req;
    logic              sh_en;
    logic              busy;
    logic              done;
    logic              timeout_err;
    logic [PASS_W-1:0] pass_idx;

    modport master (
        output start, abort, eng_done, wr_ack,
        input  ld, ui_ld, eng_start, wr_req, sh_en,
        input  busy, done, timeout_err, pass_idx
    );

    modport slave (
        input  start, abort, eng_done, wr_ack,
        output ld, ui_ld, eng_start, wr_req, sh_en,
        output busy, done, timeout_err, pass_idx
    );
endinterface

// File: rtl/wrapper_pass_sequencer_watchdog.sv
// Engine-wait watchdog: counts enabled cycles, flags the last allowed one.
module wrapper_pass_sequencer_watchdog
    import wrapper_pass_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int TO_W = clog2_min1(TIMEOUT_CYC + 1);

    generate
        if (TIMEOUT_CYC == 0) begin : g_off
            logic unused_in;
            assign unused_in = ^{clk, rst, clr, en};
            assign expire    = 1'b0;
        end else begin : g_on
            localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);
            logic [TO_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clr)     cnt_d = '0;
                else if (en) cnt_d = cnt_q + 1'b1;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) cnt_q <= '0;
                else     cnt_q <= cnt_d;
            end

            assign expire = en && (cnt_q == LAST);
        end
    endgenerate
endmodule

// File: rtl/wrapper_pass_sequencer.sv
// Runs the engine NUM_PASSES times per loaded job: kick, wait, write, shift.
module wrapper_pass_sequencer
    import wrapper_pass_sequencer_pkg::*;
#(
    parameter int NUM_PASSES  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    wrapper_pass_sequencer_if.slave bus
);
    localparam int PASS_W = clog2_min1(NUM_PASSES);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);

    state_t            state_q, state_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic              err_q, err_d;
    logic              wd_expire;
    logic              aborting;

    assign aborting = bus.abort && (state_q != S_IDLE);

    wrapper_pass_sequencer_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wd (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q == S_KICK),
        .en     (state_q == S_WAIT),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pass_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    pass_d  = '0;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (!bus.start) state_d = S_KICK;
            end
            S_KICK: state_d = S_WAIT;
            S_WAIT: begin
                // completion outranks a watchdog expiry in the same cycle
                if (bus.eng_done) begin
                    state_d = S_WRITE;
                end else if (wd_expire) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_WRITE: begin
                if (bus.wr_ack) begin
                    if (pass_q == LAST_PASS) begin
                        state_d = S_IDLE;
                    end else begin
                        pass_d  = pass_q + 1'b1;
                        state_d = S_KICK;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (aborting) begin
            state_d = S_IDLE;
            pass_d  = '0;
            err_d   = err_q;
        end
    end

    always_comb begin
        bus.ld        = 1'b0;
        bus.ui_ld     = 1'b0;
        bus.eng_start = 1'b0;
        bus.wr_req    = 1'b0;
        bus.sh_en     = 1'b0;
        bus.done      = 1'b0;
        unique case (state_q)
            S_IDLE:  bus.done = 1'b1;
            S_LOAD: begin
                bus.ld    = 1'b1;
                bus.ui_ld = 1'b1;
            end
            S_KICK:  bus.eng_start = !aborting;
            S_WAIT:  ;
            S_WRITE: begin
                bus.wr_req = 1'b1;
                bus.sh_en  = bus.wr_ack && !aborting;
            end
            default: ;
        endcase
        bus.busy        = !bus.done;
        bus.timeout_err = err_q;
        bus.pass_idx    = pass_q;
    end
endmodule
